// File: rtl/sdp_sram_ctrl.sv
// Simple dual-port SRAM: one byte-masked write port and one pipelined read port,
// with selectable read latency, read-during-write policy and an optional zero-fill sweep.
module sdp_sram_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int WR_MODE    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  input  logic                  enb,
  input  logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     doutb,
  output logic                  doutb_valid,
  output logic                  collision
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en, rd_en, rd_in_range, hit;
  logic [DATA_W-1:0]   old_word, merged, rd_word;
  logic [DATA_W-1:0]   s1_data;
  logic                s1_valid, s1_hit;

  // A hit only counts when the write really lands, so out-of-range or masked-off writes never collide.
  always_comb begin
    wr_en       = (state == READY) && ena && (|wea) && ({1'b0, addra} < DEPTH_L);
    rd_en       = (state == READY) && enb;
    rd_in_range = {1'b0, addrb} < DEPTH_L;
    old_word    = rd_in_range ? mem[addrb] : '0;
    hit         = wr_en && rd_en && (addra == addrb);
    merged      = old_word;
    for (int i = 0; i < NB; i++)
      if (wea[i]) merged[8*i +: 8] = dina[8*i +: 8];
    rd_word     = (WR_MODE == 1 && hit) ? merged : old_word;
  end

  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= (INIT_CLEAR != 0) ? INIT : READY;
      init_busy   <= (INIT_CLEAR != 0);
      cnt         <= '0;
      s1_data     <= '0;
      s1_valid    <= 1'b0;
      s1_hit      <= 1'b0;
      doutb       <= '0;
      doutb_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      if (state == INIT) begin
        if (cnt == LAST) begin
          state     <= READY;
          init_busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= rd_word;
        s1_hit  <= hit;
      end

      // doutb only moves when a read completes, so it holds across idle cycles.
      if (RD_LAT == 2) begin
        doutb_valid <= s1_valid;
        collision   <= s1_valid && s1_hit;
        if (s1_valid) doutb <= s1_data;
      end else begin
        doutb_valid <= rd_en;
        collision   <= hit;
        if (rd_en) doutb <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_sdp_sram_ctrl.sv
// Bench for sdp_sram_ctrl: two instances (read-first/latency 1/depth 16 and
// write-first/latency 2/depth 12) share stimulus and are checked against a scoreboard.
module tb_sdp_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0, enb = 1'b0;
  logic [1:0]  wea = 2'b00;
  logic [3:0]  addra = 4'd0, addrb = 4'd0;
  logic [15:0] dina = 16'h0;

  logic        busyO [2];
  logic [15:0] doutbO [2];
  logic        validO [2];
  logic        collO [2];

  always #5 clk = ~clk;

  sdp_sram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .WR_MODE(0), .INIT_CLEAR(1)) dutA (
    .clk(clk), .rst_n(rst_n), .init_busy(busyO[0]), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutbO[0]), .doutb_valid(validO[0]),
    .collision(collO[0]));

  sdp_sram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .WR_MODE(1), .INIT_CLEAR(1)) dutB (
    .clk(clk), .rst_n(rst_n), .init_busy(busyO[1]), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutbO[1]), .doutb_valid(validO[1]),
    .collision(collO[1]));

  typedef struct packed {
    logic        ena;
    logic [1:0]  wea;
    logic [3:0]  addra;
    logic [15:0] dina;
    logic        enb;
    logic [3:0]  addrb;
  } stim_t;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        coll;
  } rd_t;

  rd_t         q0[$], q1[$];
  logic [15:0] mm [2][16];
  int          rem [2];
  logic [15:0] last [2];
  logic        expV [2], expC [2], expBusy [2];
  logic [15:0] expD [2];
  int          cyc = 0;
  int          total = 0, passed = 0;

  function automatic int depOf(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int modeOf(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic stim_t mk(input logic e, input logic [1:0] w, input logic [3:0] aa,
                               input logic [15:0] d, input logic r, input logic [3:0] ab);
    stim_t s;
    s.ena = e; s.wea = w; s.addra = aa; s.dina = d; s.enb = r; s.addrb = ab;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ena = s.ena; wea = s.wea; addra = s.addra; dina = s.dina; enb = s.enb; addrb = s.addrb;
  endtask

  // One clock edge: the model sees the same inputs, queues the reads issued, then pops what is due.
  task automatic tick();
    rd_t e;
    logic have;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rem[k] > 0) begin
        mm[k][4'(depOf(k) - rem[k])] = 16'h0;
        rem[k]--;
      end else begin
        if (enb) begin
          logic [15:0] old, mrg;
          logic h;
          old = (int'(addrb) < depOf(k)) ? mm[k][addrb] : 16'h0;
          h = ena && (|wea) && (addra == addrb) && (int'(addra) < depOf(k));
          mrg = {wea[1] ? dina[15:8] : old[15:8], wea[0] ? dina[7:0] : old[7:0]};
          e.due  = cyc + latOf(k) - 1;
          e.data = (h && modeOf(k) == 1) ? mrg : old;
          e.coll = h;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (ena && int'(addra) < depOf(k)) begin
          if (wea[0]) mm[k][addra][7:0]  = dina[7:0];
          if (wea[1]) mm[k][addra][15:8] = dina[15:8];
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      have = 1'b0;
      if (k == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
      end
      expV[k] = have;
      expC[k] = have ? e.coll : 1'b0;
      if (have) last[k] = e.data;
      expD[k] = last[k];
      expBusy[k] = (rem[k] > 0);
    end
  endtask

  task automatic applyReset();
    drive(mk(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0));
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    rem[0] = 16;
    rem[1] = 12;
    for (int k = 0; k < 2; k++) begin
      last[k] = 16'h0; expV[k] = 1'b0; expC[k] = 1'b0; expD[k] = 16'h0; expBusy[k] = 1'b1;
    end
    #1;
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    applyReset();
    for (int k = 0; k < 2; k++) begin
      total++; if (doutbO[k] !== 16'h0) $display("[TB] FAIL reset_doutb[%0d]: got %h expected 0000", k, doutbO[k]); else passed++;
      total++; if (validO[k] !== 1'b0) $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", k, validO[k]); else passed++;
      total++; if (collO[k] !== 1'b0) $display("[TB] FAIL reset_coll[%0d]: got %b expected 0", k, collO[k]); else passed++;
      total++; if (busyO[k] !== 1'b1) $display("[TB] FAIL reset_busy[%0d]: got %b expected 1", k, busyO[k]); else passed++;
    end
    releaseReset();
  endtask

  task automatic test_zero_fill();
    int busyN [2];
    $display("[TB] test_zero_fill");
    busyN[0] = 0; busyN[1] = 0;
    drive(mk(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd0));
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 2; k++) if (busyO[k] === 1'b1) busyN[k]++;
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL fill_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL fill_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (collO[k] !== expC[k]) $display("[TB] FAIL fill_coll[%0d] cyc %0d: got %b expected %b", k, cyc, collO[k], expC[k]); else passed++;
        total++; if (busyO[k] !== expBusy[k]) $display("[TB] FAIL fill_busy[%0d] cyc %0d: got %b expected %b", k, cyc, busyO[k], expBusy[k]); else passed++;
      end
    end
    total++; if (busyN[0] != 16) $display("[TB] FAIL fill_busy_len[0]: got %0d edges expected 16", busyN[0]); else passed++;
    total++; if (busyN[1] != 12) $display("[TB] FAIL fill_busy_len[1]: got %0d edges expected 12", busyN[1]); else passed++;
    for (int a = 0; a < 18; a++) begin
      drive(mk(1'b0, 2'b00, 4'd0, 16'h0, (a < 16), 4'(a)));
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL zero_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== 16'h0) $display("[TB] FAIL zero_doutb[%0d] cyc %0d: got %h expected 0000", k, cyc, doutbO[k]); else passed++;
      end
    end
  endtask

  task automatic test_basic_rw();
    stim_t s[$];
    $display("[TB] test_basic_rw");
    s.push_back(mk(1'b1, 2'b11, 4'd0, 16'h0065, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 2'b11, 4'd1, 16'h008B, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd1));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL rw_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL rw_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (collO[k] !== expC[k]) $display("[TB] FAIL rw_coll[%0d] cyc %0d: got %b expected %b", k, cyc, collO[k], expC[k]); else passed++;
      end
      if (i == 2) begin
        total++; if (doutbO[0] !== 16'h0065 || validO[0] !== 1'b1) $display("[TB] FAIL rw_lat1_first: got %h/%b expected 0065/1", doutbO[0], validO[0]); else passed++;
        total++; if (validO[1] !== 1'b0) $display("[TB] FAIL rw_lat2_early: got valid %b expected 0", validO[1]); else passed++;
      end
      if (i == 3) begin
        total++; if (doutbO[1] !== 16'h0065 || validO[1] !== 1'b1) $display("[TB] FAIL rw_lat2_first: got %h/%b expected 0065/1", doutbO[1], validO[1]); else passed++;
      end
      if (i == 4) begin
        total++; if (doutbO[1] !== 16'h008B || validO[1] !== 1'b1) $display("[TB] FAIL rw_lat2_second: got %h/%b expected 008b/1", doutbO[1], validO[1]); else passed++;
        total++; if (doutbO[0] !== 16'h008B || validO[0] !== 1'b0) $display("[TB] FAIL rw_idle_hold: got %h/%b expected 008b/0", doutbO[0], validO[0]); else passed++;
      end
    end
  endtask

  task automatic test_byte_enables();
    stim_t s[$];
    $display("[TB] test_byte_enables");
    s.push_back(mk(1'b1, 2'b11, 4'd3, 16'hAABB, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 2'b01, 4'd3, 16'h1122, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 2'b00, 4'd3, 16'h5555, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd3));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL be_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL be_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
      end
      if (i == 3) begin
        total++; if (doutbO[0] !== 16'hAA22) $display("[TB] FAIL be_merge_a: got %h expected aa22", doutbO[0]); else passed++;
      end
      if (i == 4) begin
        total++; if (doutbO[1] !== 16'hAA22) $display("[TB] FAIL be_merge_b: got %h expected aa22", doutbO[1]); else passed++;
      end
    end
  endtask

  task automatic test_collision();
    stim_t s[$];
    $display("[TB] test_collision");
    s.push_back(mk(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b1, 4'd5));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b1, 4'd5));
    s.push_back(mk(1'b1, 2'b01, 4'd5, 16'h00CD, 1'b1, 4'd5));
    s.push_back(mk(1'b1, 2'b00, 4'd6, 16'h9999, 1'b1, 4'd6));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL col_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL col_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (collO[k] !== expC[k]) $display("[TB] FAIL col_coll[%0d] cyc %0d: got %b expected %b", k, cyc, collO[k], expC[k]); else passed++;
      end
      if (i == 1) begin
        total++; if (doutbO[0] !== 16'h1234 || collO[0] !== 1'b1) $display("[TB] FAIL col_read_first: got %h/%b expected 1234/1", doutbO[0], collO[0]); else passed++;
      end
      if (i == 2) begin
        total++; if (doutbO[1] !== 16'hBEEF || collO[1] !== 1'b1) $display("[TB] FAIL col_write_first: got %h/%b expected beef/1", doutbO[1], collO[1]); else passed++;
        total++; if (doutbO[0] !== 16'hBEEF || collO[0] !== 1'b0) $display("[TB] FAIL col_followup: got %h/%b expected beef/0", doutbO[0], collO[0]); else passed++;
      end
      if (i == 4) begin
        total++; if (doutbO[1] !== 16'hBECD || collO[1] !== 1'b1) $display("[TB] FAIL col_partial_merge: got %h/%b expected becd/1", doutbO[1], collO[1]); else passed++;
      end
    end
  endtask

  task automatic test_out_of_range();
    stim_t s[$];
    $display("[TB] test_out_of_range");
    s.push_back(mk(1'b1, 2'b11, 4'd13, 16'h7777, 1'b0, 4'd0));
    s.push_back(mk(1'b1, 2'b11, 4'd12, 16'h5555, 1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b1, 4'd13));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b1, 4'd1));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b1, 4'd12));
    s.push_back(mk(1'b1, 2'b11, 4'd14, 16'h1111, 1'b1, 4'd14));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b1, 4'd11));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b0, 4'd0));
    s.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0,    1'b0, 4'd0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL oor_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL oor_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (collO[k] !== expC[k]) $display("[TB] FAIL oor_coll[%0d] cyc %0d: got %b expected %b", k, cyc, collO[k], expC[k]); else passed++;
      end
      if (i == 3) begin
        total++; if (doutbO[1] !== 16'h0 || validO[1] !== 1'b1) $display("[TB] FAIL oor_read13: got %h/%b expected 0000/1", doutbO[1], validO[1]); else passed++;
      end
      if (i == 4) begin
        total++; if (doutbO[1] !== 16'h008B) $display("[TB] FAIL oor_word1: got %h expected 008b", doutbO[1]); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    for (int n = 0; n < 60; n++) begin
      ena   = 1'($urandom_range(0, 1));
      wea   = 2'($urandom_range(0, 3));
      addra = 4'($urandom_range(0, 15));
      dina  = 16'($urandom);
      enb   = (n < 56) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      addrb = ($urandom_range(0, 2) == 0) ? addra : 4'($urandom_range(0, 15));
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL b2b_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL b2b_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (collO[k] !== expC[k]) $display("[TB] FAIL b2b_coll[%0d] cyc %0d: got %b expected %b", k, cyc, collO[k], expC[k]); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int busyN [2];
    $display("[TB] test_reset_mid");
    drive(mk(1'b1, 2'b11, 4'd3, 16'hC0DE, 1'b0, 4'd0));
    tick();
    drive(mk(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3));
    tick();
    total++; if (doutbO[0] !== 16'hC0DE || validO[0] !== 1'b1) $display("[TB] FAIL mid_pre_read: got %h/%b expected c0de/1", doutbO[0], validO[0]); else passed++;
    applyReset();
    for (int k = 0; k < 2; k++) begin
      total++; if (validO[k] !== 1'b0) $display("[TB] FAIL mid_valid[%0d]: got %b expected 0", k, validO[k]); else passed++;
      total++; if (doutbO[k] !== 16'h0) $display("[TB] FAIL mid_doutb[%0d]: got %h expected 0000", k, doutbO[k]); else passed++;
      total++; if (busyO[k] !== 1'b1) $display("[TB] FAIL mid_busy[%0d]: got %b expected 1", k, busyO[k]); else passed++;
    end
    releaseReset();
    busyN[0] = 0; busyN[1] = 0;
    drive(mk(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3));
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 2; k++) if (busyO[k] === 1'b1) busyN[k]++;
      if (n == 18) enb = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        total++; if (validO[k] !== expV[k]) $display("[TB] FAIL mid_sweep_valid[%0d] cyc %0d: got %b expected %b", k, cyc, validO[k], expV[k]); else passed++;
        total++; if (doutbO[k] !== expD[k]) $display("[TB] FAIL mid_sweep_doutb[%0d] cyc %0d: got %h expected %h", k, cyc, doutbO[k], expD[k]); else passed++;
        total++; if (busyO[k] !== expBusy[k]) $display("[TB] FAIL mid_sweep_busy[%0d] cyc %0d: got %b expected %b", k, cyc, busyO[k], expBusy[k]); else passed++;
      end
    end
    total++; if (busyN[0] != 16) $display("[TB] FAIL mid_busy_len[0]: got %0d edges expected 16", busyN[0]); else passed++;
    total++; if (busyN[1] != 12) $display("[TB] FAIL mid_busy_len[1]: got %0d edges expected 12", busyN[1]); else passed++;
  endtask

  initial begin
    #2;
    test_reset();
    test_zero_fill();
    test_basic_rw();
    test_byte_enables();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
